// File: rtl/gsim_xcollect_if.sv
// Stream bundle between the x-vector collector and its neighbours.
// The collector is the master: it sources the replay stream and error flags.
interface gsim_xcollect_if #(
  parameter int N     = 16,
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  localparam int IDX_W = $clog2(N);

  logic              in_valid;
  logic [IN_W-1:0]   x_in;
  logic              o_valid;
  logic              o_ready;
  logic [OUT_W-1:0]  o_data;
  logic [IDX_W-1:0]  o_idx;
  logic              o_last;
  logic              busy;
  logic              err_short;
  logic              err_overrun;

  modport master (
    input  in_valid, x_in, o_ready,
    output o_valid, o_data, o_idx, o_last, busy, err_short, err_overrun
  );

  modport slave (
    output in_valid, x_in, o_ready,
    input  o_valid, o_data, o_idx, o_last, busy, err_short, err_overrun
  );
endinterface

// File: rtl/gsim_xcollect.sv
// Captures one N-word Q(IN_W-FRAC).FRAC burst from the solver, converts each word
// to a rounded, saturated OUT_W integer and replays the frame on a valid/ready stream.
module gsim_xcollect #(
  parameter int N     = 16,
  parameter int IN_W  = 32,
  parameter int FRAC  = 16,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  gsim_xcollect_if.master  bus
);
  localparam int IDX_W = $clog2(N);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [IDX_W-1:0] LAST   = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] PENULT = IDX_W'(N - 2);

  localparam logic signed [IN_W:0] HALF    = {{IN_W{1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic [1:0]        state;
  logic [IDX_W-1:0]  wcnt;
  logic [IDX_W-1:0]  rptr;
  logic [IDX_W-1:0]  rptr_nxt;
  logic              prev_v;
  logic [OUT_W-1:0]  mem [N];

  logic              o_valid_q;
  logic              o_last_q;
  logic              busy_q;
  logic              err_short_q;
  logic              err_overrun_q;
  logic [OUT_W-1:0]  o_data_q;

  logic              burst_start;
  logic signed [IN_W:0] x_ext;
  logic signed [IN_W:0] rnd;
  logic signed [IN_W:0] q;
  logic [OUT_W-1:0]  conv;

  assign burst_start = bus.in_valid & ~prev_v;
  assign rptr_nxt    = rptr + 1'b1;

  // Round half up in one extra bit so the +0.5 can never wrap, then clamp.
  // NOTE: every path assigns conv, so this block stays purely combinational (no latch).
  always_comb begin
    x_ext = $signed({bus.x_in[IN_W-1], bus.x_in});
    rnd   = x_ext + HALF;
    q     = rnd >>> FRAC;
    if (q > SAT_MAX)
      conv = {1'b0, {(OUT_W - 1){1'b1}}};
    else if (q < SAT_MIN)
      conv = {1'b1, {(OUT_W - 1){1'b0}}};
    else
      conv = q[OUT_W-1:0];
  end

  // NOTE: all state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      wcnt          <= '0;
      rptr          <= '0;
      prev_v        <= 1'b0;
      o_valid_q     <= 1'b0;
      o_last_q      <= 1'b0;
      busy_q        <= 1'b0;
      err_short_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      o_data_q      <= '0;
      // NOTE: the buffer is small flop storage and must read as zero after reset,
      // so it is cleared here rather than left to a RAM.
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      prev_v        <= bus.in_valid;
      err_short_q   <= 1'b0;
      err_overrun_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Trailing words of a discarded burst have prev_v set and are ignored.
          if (burst_start) begin
            mem[0] <= conv;
            wcnt   <= IDX_W'(1);
            busy_q <= 1'b1;
            state  <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (bus.in_valid) begin
            mem[wcnt] <= conv;
            wcnt      <= wcnt + 1'b1;
            if (wcnt == LAST) begin
              state     <= ST_DRAIN;
              rptr      <= '0;
              o_valid_q <= 1'b1;
              o_last_q  <= 1'b0;
              o_data_q  <= mem[0];
            end
          end else begin
            err_short_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          // Continuing input words are dropped; only a fresh burst is an error.
          if (burst_start) err_overrun_q <= 1'b1;
          if (bus.o_ready) begin
            rptr     <= rptr_nxt;
            o_data_q <= mem[rptr_nxt];
            o_last_q <= (rptr == PENULT);
            if (rptr == LAST) begin
              o_valid_q <= 1'b0;
              o_last_q  <= 1'b0;
              busy_q    <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          o_valid_q <= 1'b0;
          o_last_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_valid     = o_valid_q;
  assign bus.o_data      = o_data_q;
  assign bus.o_idx       = rptr;
  assign bus.o_last      = o_last_q;
  assign bus.busy        = busy_q;
  assign bus.err_short   = err_short_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_gsim_xcollect.sv
// Bench for gsim_xcollect: random and directed bursts checked against a
// frame-level reference model built from floor-division rounding and clamping.
module tb_gsim_xcollect;
  localparam int N     = 16;
  localparam int IN_W  = 32;
  localparam int FRAC  = 16;
  localparam int OUT_W = 16;
  localparam int IDX_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gsim_xcollect_if #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  gsim_xcollect #(.N(N), .IN_W(IN_W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int rcnt = 0;
  int cyc = 0;

  logic [IN_W-1:0]  stim[$];
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] got_data[$];
  logic [IDX_W-1:0] got_idx[$];
  logic             got_last[$];
  int               got_cyc[$];
  int valid_cycles = 0, short_cycles = 0, ovr_cycles = 0, stall_viol = 0;
  logic             stalled = 1'b0;
  logic [OUT_W-1:0] hold_data = '0;
  logic [IDX_W-1:0] hold_idx = '0;

  // Consumer readiness: always ready, the 1,0,0 pattern, or random.
  always @(posedge clk) begin
    #1;
    rcnt++;
    case (rdy_mode)
      0:       bus.o_ready = 1'b1;
      1:       bus.o_ready = (rcnt % 3 == 0);
      default: bus.o_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Observe the stream mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (bus.o_valid)     valid_cycles++;
      if (bus.err_short)   short_cycles++;
      if (bus.err_overrun) ovr_cycles++;
      if (stalled && (!bus.o_valid || bus.o_data !== hold_data || bus.o_idx !== hold_idx))
        stall_viol++;
      stalled   = bus.o_valid && !bus.o_ready;
      hold_data = bus.o_data;
      hold_idx  = bus.o_idx;
      if (bus.o_valid && bus.o_ready) begin
        got_data.push_back(bus.o_data);
        got_idx.push_back(bus.o_idx);
        got_last.push_back(bus.o_last);
        got_cyc.push_back(cyc);
      end
    end
  end

  // Reference conversion: floor(x / 2^FRAC + 1/2), clamped to the int16 range.
  function automatic logic [OUT_W-1:0] model_conv(input logic [IN_W-1:0] w);
    longint v, num, scale, qv;
    scale = longint'(1) << FRAC;
    v     = longint'($signed(w));
    num   = v + scale / 2;
    qv    = num / scale;
    if (num < 0 && (num % scale) != 0) qv = qv - 1;
    if (qv > 32767)  qv = 32767;
    if (qv < -32768) qv = -32768;
    return qv[OUT_W-1:0];
  endfunction

  function automatic logic [IN_W-1:0] rand_word();
    logic [IN_W-1:0] w;
    case ($urandom_range(0, 3))
      0:       w = $urandom;
      1:       w = {($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000, 16'($urandom)};
      2:       w = {16'($urandom), 16'h8000};
      default: w = 32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000;
    endcase
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic make_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(rand_word());
  endtask

  task automatic model_frame();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(model_conv(stim[i]));
  endtask

  task automatic drive_stim();
    foreach (stim[i]) begin
      bus.in_valid = 1'b1;
      bus.x_in     = stim[i];
      tick();
    end
  endtask

  task automatic clear_obs();
    got_data.delete();
    got_idx.delete();
    got_last.delete();
    got_cyc.delete();
    valid_cycles = 0;
    short_cycles = 0;
    ovr_cycles   = 0;
    stall_viol   = 0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.x_in = '0;
    repeat (3) tick();
    checks++;
    if ({bus.o_valid, bus.o_last, bus.busy, bus.err_short, bus.err_overrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: valid/last/busy/short/ovr=%b expected 00000",
               {bus.o_valid, bus.o_last, bus.busy, bus.err_short, bus.err_overrun});
    end
    checks++;
    if (bus.o_data !== 16'h0 || bus.o_idx !== 4'h0) begin
      errors++;
      $display("FAIL reset_data: o_data=%h o_idx=%0d expected 0000/0", bus.o_data, bus.o_idx);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    clear_obs();
    rdy_mode = 0;
    stim.delete();
    for (int k = 0; k < N; k++) stim.push_back(32'(k) << 16);
    model_frame();
    drive_stim();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_idx !== 4'd0) begin
      errors++;
      $display("FAIL basic_latency: o_valid=%b o_idx=%0d expected 1/0", bus.o_valid, bus.o_idx);
    end
    bus.in_valid = 1'b0;
    wait_idle(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: busy=%b expected 0", bus.busy);
    end
    checks++;
    if (got_data.size() != N) begin
      errors++;
      $display("FAIL basic_count: got %0d words expected %0d", got_data.size(), N);
    end
    for (int i = 0; i < N && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 16'(i) || got_idx[i] !== IDX_W'(i) || got_last[i] !== (i == N - 1)) begin
        errors++;
        $display("FAIL basic_word[%0d]: data=%h idx=%0d last=%b expected %h/%0d/%b",
                 i, got_data[i], got_idx[i], got_last[i], 16'(i), i, i == N - 1);
      end
    end
    checks++;
    if (got_cyc.size() == N && got_cyc[N-1] - got_cyc[0] != N - 1) begin
      errors++;
      $display("FAIL basic_throughput: span=%0d cycles expected %0d", got_cyc[N-1] - got_cyc[0], N - 1);
    end
    checks++;
    if (bus.o_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: o_valid=%b busy=%b expected 0/0", bus.o_valid, bus.busy);
    end
  endtask

  task automatic test_rounding();
    bit ok;
    logic [OUT_W-1:0] want[5];
    want = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
    clear_obs();
    rdy_mode = 2;
    make_random(N);
    stim[0] = 32'h0000_8000;
    stim[1] = 32'hFFFF_7FFF;
    stim[2] = 32'h7FFF_8000;
    stim[3] = 32'h8000_0000;
    stim[4] = 32'hFFFF_8000;
    model_frame();
    drive_stim();
    bus.in_valid = 1'b0;
    wait_idle(400, ok);
    checks++;
    if (!ok || got_data.size() != N) begin
      errors++;
      $display("FAIL round_count: got %0d words (idle=%0b) expected %0d", got_data.size(), ok, N);
    end
    for (int i = 0; i < 5 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== want[i]) begin
        errors++;
        $display("FAIL round_fixed[%0d]: x=%h gave %h expected %h", i, stim[i], got_data[i], want[i]);
      end
    end
    for (int i = 5; i < N && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i] || got_idx[i] !== IDX_W'(i)) begin
        errors++;
        $display("FAIL round_rand[%0d]: x=%h gave %h idx=%0d expected %h idx=%0d",
                 i, stim[i], got_data[i], got_idx[i], exp_q[i], i);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_obs();
    rdy_mode = 1;
    make_random(N);
    model_frame();
    drive_stim();
    bus.in_valid = 1'b0;
    wait_idle(400, ok);
    checks++;
    if (!ok || got_data.size() != N) begin
      errors++;
      $display("FAIL bp_count: got %0d words (idle=%0b) expected %0d", got_data.size(), ok, N);
    end
    for (int i = 0; i < N && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i] || got_idx[i] !== IDX_W'(i) || got_last[i] !== (i == N - 1)) begin
        errors++;
        $display("FAIL bp_word[%0d]: data=%h idx=%0d last=%b expected %h/%0d/%b",
                 i, got_data[i], got_idx[i], got_last[i], exp_q[i], i, i == N - 1);
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable stall cycles expected 0", stall_viol);
    end
  endtask

  task automatic test_short();
    bit ok;
    clear_obs();
    rdy_mode = 0;
    make_random(10);
    drive_stim();
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.err_short !== 1'b1) begin
      errors++;
      $display("FAIL short_pulse: err_short=%b expected 1", bus.err_short);
    end
    tick();
    checks++;
    if (bus.err_short !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL short_after: err_short=%b busy=%b expected 0/0", bus.err_short, bus.busy);
    end
    repeat (3) tick();
    checks++;
    if (valid_cycles != 0 || short_cycles != 1 || ovr_cycles != 0) begin
      errors++;
      $display("FAIL short_flags: valid=%0d short=%0d ovr=%0d expected 0/1/0",
               valid_cycles, short_cycles, ovr_cycles);
    end
    clear_obs();
    rdy_mode = 2;
    make_random(N);
    model_frame();
    drive_stim();
    bus.in_valid = 1'b0;
    wait_idle(400, ok);
    checks++;
    if (!ok || got_data.size() != N) begin
      errors++;
      $display("FAIL short_next_count: got %0d words (idle=%0b) expected %0d", got_data.size(), ok, N);
    end
    for (int i = 0; i < N && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i] || got_idx[i] !== IDX_W'(i)) begin
        errors++;
        $display("FAIL short_next[%0d]: data=%h idx=%0d expected %h/%0d",
                 i, got_data[i], got_idx[i], exp_q[i], i);
      end
    end
  endtask

  task automatic test_long();
    bit ok;
    clear_obs();
    rdy_mode = 0;
    make_random(N + 1);
    model_frame();
    drive_stim();
    bus.in_valid = 1'b0;
    wait_idle(200, ok);
    repeat (3) tick();
    checks++;
    if (!ok || got_data.size() != N || short_cycles != 0 || ovr_cycles != 0) begin
      errors++;
      $display("FAIL long_count: words=%0d short=%0d ovr=%0d expected %0d/0/0",
               got_data.size(), short_cycles, ovr_cycles, N);
    end
    for (int i = 0; i < N && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL long_word[%0d]: data=%h expected %h", i, got_data[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    // New burst while the frame is stalled in drain.
    clear_obs();
    rdy_mode = 1;
    make_random(N);
    model_frame();
    drive_stim();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    bus.in_valid = 1'b1;
    bus.x_in = rand_word();
    tick();
    checks++;
    if (bus.err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_pulse: err_overrun=%b expected 1", bus.err_overrun);
    end
    for (int i = 0; i < 4; i++) begin
      bus.x_in = rand_word();
      tick();
    end
    bus.in_valid = 1'b0;
    wait_idle(400, ok);
    repeat (20) tick();
    checks++;
    if (!ok || got_data.size() != N || ovr_cycles != 1) begin
      errors++;
      $display("FAIL ovr_count: words=%0d ovr_cycles=%0d expected %0d/1", got_data.size(), ovr_cycles, N);
    end
    for (int i = 0; i < N && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovr_word[%0d]: data=%h expected %h", i, got_data[i], exp_q[i]);
      end
    end

    // Burst start on the same edge as the final handshake.
    clear_obs();
    rdy_mode = 0;
    make_random(N);
    drive_stim();
    bus.in_valid = 1'b0;
    repeat (N - 1) tick();
    bus.in_valid = 1'b1;
    bus.x_in = rand_word();
    tick();
    checks++;
    if (bus.err_overrun !== 1'b1 || bus.busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_same_edge: err_overrun=%b busy=%b o_valid=%b expected 1/0/0",
               bus.err_overrun, bus.busy, bus.o_valid);
    end
    repeat (3) tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (bus.busy !== 1'b0 || got_data.size() != N || valid_cycles != N) begin
      errors++;
      $display("FAIL ovr_same_edge_discard: busy=%b words=%0d valid_cycles=%0d expected 0/%0d/%0d",
               bus.busy, got_data.size(), valid_cycles, N, N);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    clear_obs();
    rdy_mode = 0;
    make_random(N);
    model_frame();
    drive_stim();
    bus.in_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.o_valid && bus.o_idx == 4'd5) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid_reach: o_idx=%0d never reached 5", bus.o_idx);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.o_valid, bus.o_last, bus.busy, bus.err_short, bus.err_overrun} !== 5'b0 ||
        bus.o_data !== 16'h0 || bus.o_idx !== 4'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: flags=%b o_data=%h o_idx=%0d expected 00000/0000/0",
               {bus.o_valid, bus.o_last, bus.busy, bus.err_short, bus.err_overrun}, bus.o_data, bus.o_idx);
    end
    reset = 1'b0;
    checks++;
    if (got_data.size() != 5) begin
      errors++;
      $display("FAIL rstmid_partial: got %0d words expected 5", got_data.size());
    end
    for (int i = 0; i < 5 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rstmid_word[%0d]: data=%h expected %h", i, got_data[i], exp_q[i]);
      end
    end
    clear_obs();
    repeat (10) tick();
    checks++;
    if (valid_cycles != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: %0d valid cycles after reset expected 0", valid_cycles);
    end
    rdy_mode = 2;
    make_random(N);
    model_frame();
    drive_stim();
    bus.in_valid = 1'b0;
    wait_idle(400, ok);
    checks++;
    if (!ok || got_data.size() != N) begin
      errors++;
      $display("FAIL rstmid_next_count: got %0d words (idle=%0b) expected %0d", got_data.size(), ok, N);
    end
    for (int i = 0; i < N && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i] || got_last[i] !== (i == N - 1)) begin
        errors++;
        $display("FAIL rstmid_next[%0d]: data=%h last=%b expected %h/%b",
                 i, got_data[i], got_last[i], exp_q[i], i == N - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    repeat (2) tick();
    test_rounding();
    repeat (2) tick();
    test_backpressure();
    repeat (2) tick();
    test_short();
    repeat (2) tick();
    test_long();
    repeat (2) tick();
    test_overrun();
    repeat (2) tick();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
